alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked execution unit: RV32I integer ops plus RV32M mul/div.
//  Sits in EX stage between operand-read and writeback.
//  Simple ops take 1 cycle; MUL*/DIV*/REM* run on an iterative 1-bit/cycle datapath.
//  Registered result with valid/ready on both sides; flush aborts in-flight work.
// PARAMETERS
//  XLEN  32  operand/result width (>=8, power of 2)
//  OP_W  8   opcode width; encodings are the `ALU_* macros in constants.vh
//            (existing ADD..SRA plus SLTU, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
// PORTS
//  i_clk     in   1      clock, all state updates on rising edge
//  i_rst     in   1      synchronous, active-high reset
//  i_flush   in   1      abort current op and drop held result
//  i_valid   in   1      operands/opcode valid
//  o_ready   out  1      unit can accept an op this cycle
//  i_op      in   OP_W   opcode
//  i_op_1    in   XLEN   operand 1 (rs1)
//  i_op_2    in   XLEN   operand 2 (rs2/imm)
//  o_valid   out  1      o_result valid
//  i_ready   in   1      consumer accepts o_result
//  o_result  out  XLEN   result
//  o_div0    out  1      divide-by-zero flag, qualified by o_valid
// BEHAVIOUR
//  Reset: state=IDLE, o_valid=0, o_result=0, o_div0=0, o_ready=0 in reset cycle, 1 after.
//  Accept: i_valid & o_ready at edge T. o_ready = (state==IDLE) & (!o_valid | i_ready).
//  Output: o_valid/o_result/o_div0 held stable until i_valid-independent i_ready=1;
//   valid drops on the edge where i_ready=1 unless a new result loads the same edge.
//  FSM: IDLE -> (simple op or div special case) stay IDLE, result loads at T+1.
//   IDLE -> MUL or DIV on mul/div accept; iterate exactly XLEN cycles, counter XLEN-1..0;
//   at count 0 -> DONE: apply sign fix, load result, o_valid=1 at T+XLEN+1 -> IDLE.
//   Throughput: simple ops 1/cycle back-to-back; mul/div block o_ready until DONE.
//  Arithmetic (all mod 2^XLEN):
//   ADD/SUB wrap; SLT signed, SLTU unsigned compare -> 0/1 zero-extended.
//   SLL/SRL/SRA use i_op_2[$clog2(XLEN)-1:0] only; SRA replicates bit XLEN-1.
//   MUL low XLEN bits; MULH s*s, MULHSU s*u, MULHU u*u, upper XLEN bits of 2*XLEN product.
//   DIV/REM signed, truncate toward zero; rem sign = dividend sign.
//  Boundaries:
//   divisor 0: quotient = all-ones, rem = i_op_1, o_div0=1, 1-cycle path, no FSM entry.
//   signed overflow (-2^(XLEN-1) / -1): DIV = i_op_1, REM = 0, 1-cycle path.
//   undefined opcode: result 0, 1-cycle, no error flag.
//   i_flush: next edge state=IDLE, o_valid=0, counter cleared; flush dominates accept
//    in the same cycle (op not taken); i_rst dominates i_flush.
//   i_rst mid-iteration: identical to reset; no partial result is ever presented.
//   Operands captured at accept; later changes on i_op_1/i_op_2/i_op ignored.
// TESTING
//  ADD 0xFFFFFFFF+1 then SUB 0-1 back-to-back, i_ready=1 -> 0x0, 0xFFFFFFFF on T+1,T+2.
//  SRA 0x80000000 by 0x24 -> 0xF8000000 (shift 4); SLTU 1<0xFFFFFFFF -> 1, SLT -> 0.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x0; MULHU same -> 0xFFFFFFFE; valid exactly at T+33.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; DIVU 7/0 -> 0xFFFFFFFF, o_div0=1;
//   REM -7/2 -> 0xFFFFFFFF at T+33.
//  Backpressure: i_ready=0 for 5 cycles after DIV done -> o_result stable, o_ready=0.
//  i_flush at cycle 10 of a MUL, then i_rst mid-DIV -> o_valid never rises; next ADD correct.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake bundle for the alu_seq execution unit: operand/opcode request side
// and registered result side, each with valid/ready.
interface alu_seq_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 8
) ();
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [OP_W-1:0] i_op;
    logic [XLEN-1:0] i_op_1;
    logic [XLEN-1:0] i_op_2;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_div0;

    modport master (
        output i_flush, i_valid, i_op, i_op_1, i_op_2, i_ready,
        input  o_ready, o_valid, o_result, o_div0
    );

    modport slave (
        input  i_flush, i_valid, i_op, i_op_1, i_op_2, i_ready,
        output o_ready, o_valid, o_result, o_div0
    );
endinterface

// File: rtl/alu_seq.sv
// RV32I/RV32M execution unit: single-cycle integer ops, 1-bit/cycle iterative
// multiply and restoring divide, registered result with valid/ready handshake.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int OP_W = 8
) (
    input  logic      i_clk,
    input  logic      i_rst,
    alu_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [OP_W-1:0] ALU_ADD    = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_SUB    = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_SLL    = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_SLT    = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_SLTU   = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_XOR    = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_SRL    = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_SRA    = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_OR     = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_AND    = OP_W'(9);
    localparam logic [OP_W-1:0] ALU_MUL    = OP_W'(10);
    localparam logic [OP_W-1:0] ALU_MULH   = OP_W'(11);
    localparam logic [OP_W-1:0] ALU_MULHSU = OP_W'(12);
    localparam logic [OP_W-1:0] ALU_MULHU  = OP_W'(13);
    localparam logic [OP_W-1:0] ALU_DIV    = OP_W'(14);
    localparam logic [OP_W-1:0] ALU_DIVU   = OP_W'(15);
    localparam logic [OP_W-1:0] ALU_REM    = OP_W'(16);
    localparam logic [OP_W-1:0] ALU_REMU   = OP_W'(17);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, mcand;
    logic [OP_W-1:0]   op_q;
    logic              neg_q, neg_r;
    logic              vld_q, div0_q;
    logic [XLEN-1:0]   res_q;

    logic [XLEN-1:0]   a, b, mag_a, mag_b, simple_res;
    logic [OP_W-1:0]   op;
    logic              is_mul, is_div, b_zero, ovf, go_iter, a_sgn, b_sgn, simple_div0;
    logic              ready, accept;
    logic [CNT_W-1:0]  shamt;

    assign a      = bus.i_op_1;
    assign b      = bus.i_op_2;
    assign op     = bus.i_op;
    assign shamt  = b[CNT_W-1:0];
    assign ready  = !i_rst && (state == IDLE) && (!vld_q || bus.i_ready);
    assign accept = bus.i_valid && ready && !bus.i_flush;

    assign bus.o_ready  = ready;
    assign bus.o_valid  = vld_q;
    assign bus.o_result = res_q;
    assign bus.o_div0   = div0_q;

    // Decode; divide-by-zero and signed overflow are resolved here without iterating.
    always_comb begin
        is_mul  = (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
        is_div  = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
        b_zero  = (b == '0);
        ovf     = ((op == ALU_DIV) || (op == ALU_REM)) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        go_iter = is_mul || (is_div && !b_zero && !ovf);
        a_sgn   = a[XLEN-1] && ((op == ALU_MULH) || (op == ALU_MULHSU) ||
                                (op == ALU_DIV) || (op == ALU_REM));
        b_sgn   = b[XLEN-1] && ((op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM));
        mag_a   = a_sgn ? -a : a;
        mag_b   = b_sgn ? -b : b;
        simple_div0 = is_div && b_zero;
        case (op)
            ALU_ADD:  simple_res = a + b;
            ALU_SUB:  simple_res = a - b;
            ALU_SLL:  simple_res = a << shamt;
            ALU_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: simple_res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  simple_res = a ^ b;
            ALU_SRL:  simple_res = a >> shamt;
            ALU_SRA:  simple_res = $signed(a) >>> shamt;
            ALU_OR:   simple_res = a | b;
            ALU_AND:  simple_res = a & b;
            ALU_DIV, ALU_DIVU: simple_res = b_zero ? '1 : a;
            ALU_REM, ALU_REMU: simple_res = b_zero ? a : '0;
            default:  simple_res = '0;
        endcase
    end

    // One shift-add (mul) or restore-subtract (div) step, and the sign-fixed final result.
    logic [XLEN:0]     sum, sh, diff;
    logic [XLEN-1:0]   step_hi, step_lo, fin;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        sh      = {hi, lo[XLEN-1]};
        diff    = sh - {1'b0, mcand};
        step_hi = hi;
        step_lo = lo;
        if (state == MUL) begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo[XLEN-1:1]};
        end else if (state == DIV) begin
            if (!diff[XLEN]) begin
                step_hi = diff[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = sh[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        case (op_q)
            ALU_MUL:                         fin = prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fin = prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               fin = neg_q ? -step_lo : step_lo;
            ALU_REM, ALU_REMU:               fin = neg_r ? -step_hi : step_hi;
            default:                         fin = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept && go_iter) state_nxt = is_mul ? MUL : DIV;
                MUL, DIV: if (cnt == '0) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            vld_q  <= 1'b0;
            res_q  <= '0;
            div0_q <= 1'b0;
        end else if (bus.i_flush) begin
            cnt   <= '0;
            vld_q <= 1'b0;
        end else begin
            if (vld_q && bus.i_ready) vld_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (go_iter) begin
                        cnt   <= CNT_W'(XLEN-1);
                        hi    <= '0;
                        lo    <= is_mul ? mag_b : mag_a;
                        mcand <= is_mul ? mag_a : mag_b;
                        op_q  <= op;
                        neg_q <= a_sgn ^ b_sgn;
                        neg_r <= a_sgn;
                    end else begin
                        vld_q  <= 1'b1;
                        res_q  <= simple_res;
                        div0_q <= simple_div0;
                    end
                end
                MUL, DIV: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt - CNT_W'(1);
                    // Last step: result goes straight to the output register.
                    if (cnt == '0) begin
                        vld_q  <= 1'b1;
                        res_q  <= fin;
                        div0_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq: expected results queued at accept,
// checked (value, div0, latency, hold under backpressure) when the DUT presents them.
module tb_alu_seq;
    localparam logic [7:0] OP_ADD = 8'd0,  OP_SUB = 8'd1,  OP_SLL = 8'd2,  OP_SLT = 8'd3;
    localparam logic [7:0] OP_SLTU = 8'd4, OP_XOR = 8'd5,  OP_SRL = 8'd6,  OP_SRA = 8'd7;
    localparam logic [7:0] OP_OR = 8'd8,   OP_AND = 8'd9,  OP_MUL = 8'd10, OP_MULH = 8'd11;
    localparam logic [7:0] OP_MULHSU = 8'd12, OP_MULHU = 8'd13, OP_DIV = 8'd14;
    localparam logic [7:0] OP_DIVU = 8'd15, OP_REM = 8'd16, OP_REMU = 8'd17;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        div0;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(32), .OP_W(8)) bus ();
    alu_seq #(.XLEN(32), .OP_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    exp_t sb[$];
    exp_t pend_item;
    bit   pend;
    bit   head_seen;
    int   cyc;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        z;
        r = '0; z = 1'b0; p = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << b[4:0];
            OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: r = {31'b0, a < b};
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $signed(a) >>> b[4:0];
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
            OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            OP_DIV:  if (b == 0) begin r = '1; z = 1'b1; end
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                     else r = $signed(a) / $signed(b);
            OP_DIVU: if (b == 0) begin r = '1; z = 1'b1; end else r = a / b;
            OP_REM:  if (b == 0) begin r = a; z = 1'b1; end
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                     else r = $signed(a) % $signed(b);
            OP_REMU: if (b == 0) begin r = a; z = 1'b1; end else r = a % b;
            default: r = '0;
        endcase
        return {z, r};
    endfunction

    function automatic int lat_of(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= OP_MUL && op <= OP_MULHU) return 32;
        if (op >= OP_DIV && op <= OP_REMU) begin
            if (b == 0) return 0;
            if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return 32;
        end
        return 0;
    endfunction

    // One clock: check outputs and detect accept at the negedge, then advance past posedge.
    task automatic step();
        exp_t h;
        @(negedge clk);
        if (bus.o_valid && !rst) begin
            chk("result_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                h = sb[0];
                if (!head_seen) begin
                    chk({h.tag, "_latency"}, 32'(cyc - h.acc), 32'(h.lat));
                    head_seen = 1'b1;
                end
                chk(h.tag, bus.o_result, h.res);
                chk({h.tag, "_div0"}, 32'(bus.o_div0), 32'(h.div0));
                if (!bus.i_ready) chk({h.tag, "_stall_ready"}, 32'(bus.o_ready), 32'd0);
                else begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
        if (pend && !rst && !bus.i_flush && bus.i_valid && bus.o_ready) begin
            pend_item.acc = cyc + 1;
            sb.push_back(pend_item);
            pend = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ed, input int lat);
        bus.i_op = op; bus.i_op_1 = a; bus.i_op_2 = b; bus.i_valid = 1'b1;
        pend_item = '{tag: tag, res: er, div0: ed, lat: lat, acc: 0};
        pend = 1'b1;
        for (int i = 0; i < 100 && pend; i++) step();
        n_tests++;
        assert (!pend) else begin
            n_fail++;
            $error("FAIL %s_accept: got timeout expected accept", tag);
            pend = 1'b0;
        end
    endtask

    task automatic sendm(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        m = model(op, a, b);
        send(tag, op, a, b, m[31:0], m[32], lat_of(op, a, b));
    endtask

    // Drop valid and scramble operands so late changes after accept are exercised.
    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_op    = 8'($urandom_range(0, 17));
        bus.i_op_1  = $urandom;
        bus.i_op_2  = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  rop;
        logic [31:0] ra, rb;
        n_tests = 0; n_fail = 0; cyc = 0; pend = 1'b0; head_seen = 1'b0;
        rst = 1'b1;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        bus.i_op = '0; bus.i_op_1 = '0; bus.i_op_2 = '0;

        step();
        chk("rst_valid",  32'(bus.o_valid), 32'd0);
        chk("rst_ready",  32'(bus.o_ready), 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_div0",   32'(bus.o_div0), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.o_ready), 32'd1);

        send("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);
        send("sub_wrap", OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 0);
        send("sra_mask", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 0);
        send("sltu", OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
        send("slt",  OP_SLT,  32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
        send("undef_op", 8'hFF, 32'h1234_5678, 32'h1, 32'h0, 1'b0, 0);
        idle();
        send("mulh",  OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 32);
        send("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32);
        send("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        send("divu_zero", OP_DIVU, 32'h7, 32'h0, 32'hFFFF_FFFF, 1'b1, 0);
        send("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1'b0, 32);
        idle();
        drain();

        bus.i_ready = 1'b0;
        send("div_bp", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 32);
        idle();
        for (int i = 0; i < 50 && !bus.o_valid; i++) step();
        repeat (5) step();
        bus.i_ready = 1'b1;
        drain();

        send("mul_flushed", OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 32);
        idle();
        repeat (9) step();
        sb.delete(); head_seen = 1'b0;
        bus.i_flush = 1'b1; bus.i_valid = 1'b1;
        bus.i_op = OP_ADD; bus.i_op_1 = 32'd1; bus.i_op_2 = 32'd1;
        step();
        bus.i_flush = 1'b0;
        idle();
        chk("flush_ready", 32'(bus.o_ready), 32'd1);
        repeat (40) step();

        send("div_reset", OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0, 32);
        idle();
        repeat (12) step();
        rst = 1'b1;
        sb.delete(); head_seen = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (40) step();
        chk("rst_mid_ready", 32'(bus.o_ready), 32'd1);

        send("add_after", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0);
        idle();
        drain();

        for (int k = 0; k < 24; k++) begin
            rop = 8'($urandom_range(0, 17));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            sendm($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb);
            idle();
            bus.i_ready = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            bus.i_ready = 1'b1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
